// File: rtl/msc_pkg.sv
// Shared constants for the music address sequencer: song ROM map, FSM states and play modes.
package msc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2
  } seqState_t;

  typedef enum logic [1:0] {
    MODE_STOP = 2'b00,
    MODE_LOOP = 2'b01,
    MODE_NEXT = 2'b10,
    MODE_RSVD = 2'b11
  } playMode_t;

  localparam int NUM_SONG_DEF = 5;

  // Inclusive address range of each song inside the song ROM
  localparam int unsigned START_ADDR [NUM_SONG_DEF] = '{0, 250, 410, 615, 820};
  localparam int unsigned END_ADDR   [NUM_SONG_DEF] = '{249, 409, 614, 819, 1023};

endpackage

// File: rtl/msc_onehot_enc.sv
// Classifies a song-select vector as single-hot or multi-hot and encodes the index of the set bit.
module msc_onehot_enc #(
  parameter int N     = 5,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     sel,
  output logic             valid,
  output logic             multi,
  output logic [IDX_W-1:0] idx
);

  assign valid = $onehot(sel);
  assign multi = (sel != '0) && !$onehot(sel);

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (sel[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/msc_addr_seq.sv
// Song ROM address sequencer: starts songs on a one-hot select, steps through notes on tick,
// and stops, loops or chains to the next song at the end of each song.
module msc_addr_seq
  import msc_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int N_SONG = 5
) (
  input  logic                       sysclk,
  input  logic                       rst,
  input  logic [N_SONG-1:0]          sel,
  input  logic                       tick,
  input  logic                       run,
  input  logic [1:0]                 mode,
  output logic [ADDR_W-1:0]          addr,
  output logic [$clog2(N_SONG)-1:0]  song_idx,
  output logic                       playing,
  output logic                       song_end,
  output logic                       sel_err
);

  localparam int IDX_W = $clog2(N_SONG);

  seqState_t          r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [IDX_W-1:0]   r_songIdx;
  logic               r_playing;
  logic               r_songEnd;
  logic               r_selErr;

  seqState_t          w_stateNxt;
  logic [ADDR_W-1:0]  w_addrNxt;
  logic [IDX_W-1:0]   w_idxNxt;
  logic               w_songEndNxt;
  logic               w_selErrNxt;

  logic               w_selValid;
  logic               w_selMulti;
  logic [IDX_W-1:0]   w_encIdx;
  logic [IDX_W-1:0]   w_idxInc;
  logic [ADDR_W-1:0]  w_startCur;
  logic [ADDR_W-1:0]  w_endCur;
  logic [ADDR_W-1:0]  w_startSel;
  logic [ADDR_W-1:0]  w_startInc;
  logic               w_atEnd;
  logic               w_advance;
  logic               w_stopAtEnd;
  playMode_t          w_mode;

  msc_onehot_enc #(
    .N     (N_SONG),
    .IDX_W (IDX_W)
  ) u_enc (
    .sel   (sel),
    .valid (w_selValid),
    .multi (w_selMulti),
    .idx   (w_encIdx)
  );

  assign w_mode      = playMode_t'(mode);
  assign w_idxInc    = (r_songIdx == IDX_W'(N_SONG - 1)) ? '0 : r_songIdx + IDX_W'(1);
  assign w_startCur  = ADDR_W'(START_ADDR[r_songIdx]);
  assign w_endCur    = ADDR_W'(END_ADDR[r_songIdx]);
  assign w_startSel  = ADDR_W'(START_ADDR[w_encIdx]);
  assign w_startInc  = ADDR_W'(START_ADDR[w_idxInc]);
  assign w_atEnd     = (r_addr == w_endCur);
  assign w_stopAtEnd = (w_mode == MODE_STOP) || (w_mode == MODE_RSVD);
  // Any sel activity, valid or not, pre-empts the tick for this cycle
  assign w_advance   = (r_state == ST_PLAY) && tick && !w_selValid && !w_selMulti;

  always_ff @(posedge sysclk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_songIdx <= '0;
      r_playing <= 1'b0;
      r_songEnd <= 1'b0;
      r_selErr  <= 1'b0;
    end else begin
      r_state   <= w_stateNxt;
      r_addr    <= w_addrNxt;
      r_songIdx <= w_idxNxt;
      r_playing <= (w_stateNxt == ST_PLAY);
      r_songEnd <= w_songEndNxt;
      r_selErr  <= w_selErrNxt;
    end
  end

  always_comb begin
    w_stateNxt = r_state;
    if (w_selValid) begin
      w_stateNxt = run ? ST_PLAY : ST_PAUSE;
    end else if (!w_selMulti) begin
      case (r_state)
        ST_IDLE:  w_stateNxt = ST_IDLE;
        ST_PLAY: begin
          if (w_advance && w_atEnd && w_stopAtEnd) w_stateNxt = ST_IDLE;
          else if (!run)                           w_stateNxt = ST_PAUSE;
        end
        ST_PAUSE: if (run) w_stateNxt = ST_PLAY;
        default:  w_stateNxt = ST_IDLE;
      endcase
    end
  end

  // End-of-song handling: addr never passes END_ADDR, so it cannot wrap the ROM
  always_comb begin
    w_addrNxt    = r_addr;
    w_idxNxt     = r_songIdx;
    w_songEndNxt = 1'b0;
    w_selErrNxt  = w_selMulti;
    if (w_selValid) begin
      w_idxNxt  = w_encIdx;
      w_addrNxt = w_startSel;
    end else if (w_advance) begin
      if (!w_atEnd) begin
        w_addrNxt = r_addr + ADDR_W'(1);
      end else begin
        w_songEndNxt = 1'b1;
        case (w_mode)
          MODE_LOOP: w_addrNxt = w_startCur;
          MODE_NEXT: begin
            w_idxNxt  = w_idxInc;
            w_addrNxt = w_startInc;
          end
          default:   w_addrNxt = r_addr;
        endcase
      end
    end
  end

  assign addr     = r_addr;
  assign song_idx = r_songIdx;
  assign playing  = r_playing;
  assign song_end = r_songEnd;
  assign sel_err  = r_selErr;

endmodule

// File: tb/tb_msc_addr_seq.sv
// Directed self-checking bench for msc_addr_seq with hand-computed expected values.
module tb_msc_addr_seq;

  localparam int ADDR_W = 10;
  localparam int N_SONG = 5;
  localparam int IDX_W  = $clog2(N_SONG);

  logic              sysclk = 1'b0;
  logic              rst;
  logic [N_SONG-1:0] sel;
  logic              tick;
  logic              run;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] addr;
  logic [IDX_W-1:0]  song_idx;
  logic              playing;
  logic              song_end;
  logic              sel_err;

  int nChecks = 0;
  int nFails  = 0;

  msc_addr_seq #(
    .ADDR_W (ADDR_W),
    .N_SONG (N_SONG)
  ) dut (
    .sysclk   (sysclk),
    .rst      (rst),
    .sel      (sel),
    .tick     (tick),
    .run      (run),
    .mode     (mode),
    .addr     (addr),
    .song_idx (song_idx),
    .playing  (playing),
    .song_end (song_end),
    .sel_err  (sel_err)
  );

  always #5 sysclk = ~sysclk;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    nChecks++;
    if (obs != exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // sel is a one-cycle pulse; tick and run are held for the whole call
  task automatic applyStimulus(input logic [N_SONG-1:0] s, input logic t, input logic r,
                               input int cycles);
    sel  = s;
    tick = t;
    run  = r;
    for (int i = 0; i < cycles; i++) begin
      @(posedge sysclk);
      #1;
      sel = '0;
    end
  endtask

  initial begin
    rst  = 1'b1;
    sel  = '0;
    tick = 1'b0;
    run  = 1'b0;
    mode = 2'b00;
    applyStimulus('0, 1'b0, 1'b0, 2);
    checkOutput("rst_addr", int'(addr), 0);
    checkOutput("rst_idx", int'(song_idx), 0);
    checkOutput("rst_playing", int'(playing), 0);
    checkOutput("rst_song_end", int'(song_end), 0);
    checkOutput("rst_sel_err", int'(sel_err), 0);
    rst = 1'b0;

    applyStimulus(5'b00100, 1'b0, 1'b1, 1);
    checkOutput("sel2_addr", int'(addr), 410);
    checkOutput("sel2_idx", int'(song_idx), 2);
    checkOutput("sel2_playing", int'(playing), 1);
    applyStimulus('0, 1'b1, 1'b1, 3);
    checkOutput("three_ticks_addr", int'(addr), 413);

    applyStimulus(5'b00010, 1'b0, 1'b1, 1);
    checkOutput("sel1_addr", int'(addr), 250);
    applyStimulus('0, 1'b1, 1'b1, 159);
    checkOutput("song1_end_addr", int'(addr), 409);
    checkOutput("song1_no_end_yet", int'(song_end), 0);
    mode = 2'b00;
    applyStimulus('0, 1'b1, 1'b1, 1);
    checkOutput("stop_song_end", int'(song_end), 1);
    checkOutput("stop_addr", int'(addr), 409);
    checkOutput("stop_playing", int'(playing), 0);
    applyStimulus('0, 1'b1, 1'b1, 2);
    checkOutput("idle_addr", int'(addr), 409);
    checkOutput("idle_playing", int'(playing), 0);
    checkOutput("idle_song_end", int'(song_end), 0);

    applyStimulus(5'b10000, 1'b0, 1'b1, 1);
    checkOutput("sel4_addr", int'(addr), 820);
    applyStimulus('0, 1'b1, 1'b1, 203);
    checkOutput("song4_end_addr", int'(addr), 1023);
    mode = 2'b10;
    applyStimulus('0, 1'b1, 1'b1, 1);
    checkOutput("next_song_end", int'(song_end), 1);
    checkOutput("next_wrap_idx", int'(song_idx), 0);
    checkOutput("next_wrap_addr", int'(addr), 0);
    checkOutput("next_playing", int'(playing), 1);

    applyStimulus(5'b10000, 1'b0, 1'b1, 1);
    applyStimulus('0, 1'b1, 1'b1, 203);
    mode = 2'b01;
    applyStimulus('0, 1'b1, 1'b1, 1);
    checkOutput("loop_song_end", int'(song_end), 1);
    checkOutput("loop_addr", int'(addr), 820);
    checkOutput("loop_idx", int'(song_idx), 4);
    checkOutput("loop_playing", int'(playing), 1);

    applyStimulus(5'b00011, 1'b0, 1'b1, 1);
    checkOutput("multi_sel_err", int'(sel_err), 1);
    checkOutput("multi_addr", int'(addr), 820);
    checkOutput("multi_idx", int'(song_idx), 4);
    checkOutput("multi_playing", int'(playing), 1);
    applyStimulus('0, 1'b0, 1'b1, 1);
    checkOutput("sel_err_pulse", int'(sel_err), 0);
    applyStimulus(5'b00010, 1'b1, 1'b1, 1);
    checkOutput("sel_tick_addr", int'(addr), 250);
    checkOutput("sel_tick_idx", int'(song_idx), 1);

    applyStimulus(5'b01000, 1'b0, 1'b1, 1);
    checkOutput("sel3_addr", int'(addr), 615);
    applyStimulus('0, 1'b1, 1'b1, 5);
    checkOutput("song3_addr", int'(addr), 620);
    applyStimulus('0, 1'b0, 1'b0, 1);
    checkOutput("pause_playing", int'(playing), 0);
    applyStimulus('0, 1'b1, 1'b0, 3);
    checkOutput("pause_hold_addr", int'(addr), 620);
    checkOutput("pause_hold_playing", int'(playing), 0);
    applyStimulus('0, 1'b0, 1'b1, 1);
    checkOutput("resume_playing", int'(playing), 1);
    checkOutput("resume_addr", int'(addr), 620);
    applyStimulus('0, 1'b1, 1'b1, 1);
    checkOutput("resume_tick_addr", int'(addr), 621);
    applyStimulus('0, 1'b1, 1'b0, 1);
    checkOutput("tick_fall_addr", int'(addr), 622);
    checkOutput("tick_fall_playing", int'(playing), 0);
    applyStimulus('0, 1'b0, 1'b1, 1);
    applyStimulus('0, 1'b1, 1'b1, 78);
    checkOutput("pre_rst_addr", int'(addr), 700);

    rst = 1'b1;
    applyStimulus('0, 1'b1, 1'b1, 1);
    checkOutput("mid_rst_addr", int'(addr), 0);
    checkOutput("mid_rst_idx", int'(song_idx), 0);
    checkOutput("mid_rst_playing", int'(playing), 0);
    checkOutput("mid_rst_song_end", int'(song_end), 0);
    checkOutput("mid_rst_sel_err", int'(sel_err), 0);
    rst = 1'b0;

    applyStimulus(5'b00100, 1'b0, 1'b0, 1);
    checkOutput("sel_paused_addr", int'(addr), 410);
    checkOutput("sel_paused_playing", int'(playing), 0);
    applyStimulus('0, 1'b0, 1'b1, 1);
    checkOutput("unpause_playing", int'(playing), 1);
    applyStimulus('0, 1'b1, 1'b1, 204);
    checkOutput("song2_end_addr", int'(addr), 614);
    mode = 2'b11;
    applyStimulus('0, 1'b1, 1'b1, 1);
    checkOutput("rsvd_song_end", int'(song_end), 1);
    checkOutput("rsvd_addr", int'(addr), 614);
    checkOutput("rsvd_playing", int'(playing), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
